// File: rtl/mips_bus_pkg.sv
// Shared definitions for the two-master MIPS bus arbiter: Avalon widths,
// FSM state encoding and the per-master request bundle.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } bus_state_t;

  // One master's request as seen by the arbiter mux.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } av_req_t;

  // Hold counter width: wide enough for MAX_HOLD, never below 3 bits.
  function automatic int hold_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Arbitration decision: who owns the bus next, evaluated from IDLE or at
// the completion of a transfer by the current owner.
module mips_bus_rr_pick
  import mips_bus_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_HOLD   = 4,
  parameter int HOLD_W     = 3
) (
  input  logic [1:0]        req,
  input  bus_state_t        owner,
  input  logic              last_grant,
  input  logic [HOLD_W-1:0] hold_cnt,
  output bus_state_t        next_owner
);

  logic hold_full;

  // The completion being decided on counts toward the hold budget.
  assign hold_full = (int'(hold_cnt) + 1) >= MAX_HOLD;

  // Next owner: ties in IDLE go opposite last_grant (or to port 0 when fixed);
  // on completion the waiting port takes over unless port 0 keeps priority.
  always_comb begin
    next_owner = IDLE;
    unique case (owner)
      IDLE: begin
        if (&req)        next_owner = ((FIXED_PRIO != 0) || last_grant) ? GNT0 : GNT1;
        else if (req[0]) next_owner = GNT0;
        else if (req[1]) next_owner = GNT1;
      end
      GNT0: begin
        if (req[1])      next_owner = ((FIXED_PRIO != 0) && req[0] && !hold_full) ? GNT0 : GNT1;
        else if (req[0]) next_owner = GNT0;
      end
      GNT1: begin
        // Port 0 wins here in both modes: round-robin turn or fixed priority.
        if (req[0])      next_owner = GNT0;
        else if (req[1]) next_owner = GNT1;
      end
      default: next_owner = IDLE;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter in front of the shared RAM: port 0 = data,
// port 1 = instruction fetch. Owner's request is passed through unregistered.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_HOLD   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [BE_W-1:0]   s_byteenable,
  output logic [DATA_W-1:0] s_writedata,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        grant
);

  localparam int HOLD_W = hold_w(MAX_HOLD);

  bus_state_t        state, state_nxt, pick;
  logic              last_grant, last_grant_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  av_req_t [1:0]     mreq;
  av_req_t           sel;
  logic [1:0]        req;
  logic              own;

  assign mreq[0] = {m0_address, m0_read, m0_write, m0_byteenable, m0_writedata};
  assign mreq[1] = {m1_address, m1_read, m1_write, m1_byteenable, m1_writedata};
  assign req     = {m1_read | m1_write, m0_read | m0_write};
  assign own     = (state == GNT1);
  assign sel     = mreq[own];

  // Read data is a plain fan-out; only the owner's copy is meaningful.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  mips_bus_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO),
    .MAX_HOLD   (MAX_HOLD),
    .HOLD_W     (HOLD_W)
  ) u_pick (
    .req        (req),
    .owner      (state),
    .last_grant (last_grant),
    .hold_cnt   (hold_cnt),
    .next_owner (pick)
  );

  // State, last owner and hold counter; reset hands the first tie to port 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      hold_cnt   <= hold_nxt;
    end
  end

  // Next state: owner only moves on a completed transfer or when it drops out.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    hold_nxt       = hold_cnt;
    unique case (state)
      IDLE: begin
        state_nxt = pick;
        hold_nxt  = '0;
      end
      GNT0, GNT1: begin
        if (!req[own]) begin
          // Owner abandoned the request (possibly mid-wait): release the bus.
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (!s_waitrequest) begin
          state_nxt      = pick;
          last_grant_nxt = own;
          if (pick == state) begin
            if (int'(hold_cnt) < MAX_HOLD) hold_nxt = hold_cnt + 1'b1;
          end else begin
            hold_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // Slave-side mux and master stalls; reset gates everything combinationally.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    if (reset && (state != IDLE)) begin
      s_address    = sel.addr;
      s_write      = sel.write;
      s_read       = sel.read & ~sel.write;
      s_byteenable = sel.be;
      s_writedata  = sel.wdata;
      grant        = own ? 2'b10 : 2'b01;
      if (own) m1_waitrequest = s_waitrequest;
      else     m0_waitrequest = s_waitrequest;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: round-robin and fixed-priority instances share
// master stimulus; a wait-state RAM model serves whichever one is selected.
module tb_mips_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  // index 0 = round-robin instance, 1 = fixed-priority instance
  logic [1:0]        m0_wait_v, m1_wait_v, s_read_v, s_write_v;
  logic [1:0][31:0]  m0_rd_v, m1_rd_v, s_addr_v, s_wdata_v;
  logic [1:0][3:0]   s_be_v;
  logic [1:0][1:0]   grant_v;
  logic              sel;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_bus_arbiter #(.FIXED_PRIO(g), .MAX_HOLD(4)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .m0_address     (m0_address),
      .m0_read        (m0_read),
      .m0_write       (m0_write),
      .m0_byteenable  (m0_byteenable),
      .m0_writedata   (m0_writedata),
      .m0_waitrequest (m0_wait_v[g]),
      .m0_readdata    (m0_rd_v[g]),
      .m1_address     (m1_address),
      .m1_read        (m1_read),
      .m1_write       (m1_write),
      .m1_byteenable  (m1_byteenable),
      .m1_writedata   (m1_writedata),
      .m1_waitrequest (m1_wait_v[g]),
      .m1_readdata    (m1_rd_v[g]),
      .s_address      (s_addr_v[g]),
      .s_read         (s_read_v[g]),
      .s_write        (s_write_v[g]),
      .s_byteenable   (s_be_v[g]),
      .s_writedata    (s_wdata_v[g]),
      .s_waitrequest  (s_waitrequest),
      .s_readdata     (s_readdata),
      .grant          (grant_v[g])
    );
  end

  logic [31:0] s_address, s_writedata, m0_readdata, m1_readdata;
  logic        s_read, s_write, m0_waitrequest, m1_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  assign s_address      = s_addr_v[sel];
  assign s_writedata    = s_wdata_v[sel];
  assign s_read         = s_read_v[sel];
  assign s_write        = s_write_v[sel];
  assign s_byteenable   = s_be_v[sel];
  assign m0_readdata    = m0_rd_v[sel];
  assign m1_readdata    = m1_rd_v[sel];
  assign m0_waitrequest = m0_wait_v[sel];
  assign m1_waitrequest = m1_wait_v[sel];
  assign grant          = grant_v[sel];

  // RAM model: ram_wait stall cycles before each access completes
  logic [31:0] mem [0:4095];
  int          ram_wait;
  int          wcnt;
  logic        s_req;
  assign s_req         = s_read | s_write;
  assign s_waitrequest = !(s_req && (wcnt >= ram_wait));
  assign s_readdata    = mem[s_address[13:2]];

  always @(posedge clk or negedge reset)
    if (!reset)                        wcnt <= 0;
    else if (!s_req || !s_waitrequest) wcnt <= 0;
    else                               wcnt <= wcnt + 1;

  always @(posedge clk)
    if (reset && s_req && !s_waitrequest && s_write)
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[13:2]][8*b +: 8] <= s_writedata[8*b +: 8];

  // checking
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard: per-port expected transfers in issue order
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  bit starv_on = 0;
  int m0_done  = 0;
  int m1_done  = 0;

  task automatic sb_pop(input bit p);
    exp_t e;
    if ((p ? q1.size() : q0.size()) == 0) begin
      chk("sb_unexpected", {31'b0, p}, 32'hFFFF_FFFF);
      return;
    end
    e = p ? q1.pop_front() : q0.pop_front();
    chk("sb_addr", s_address, e.addr);
    chk("sb_dir", {31'b0, s_write}, {31'b0, e.wr});
    if (e.wr) chk("sb_wdata", s_writedata, e.data);
    else      chk("sb_rdata", p ? m1_readdata : m0_readdata, e.data);
    if (starv_on) begin
      if (!p) m0_done++;
      else begin
        if (m1_done < 2) chk("starve_m0_cnt", m0_done, (m1_done + 1) * 4);
        m1_done++;
      end
    end
  endtask

  // per-cycle invariants on both instances, plus completion monitor
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      chk("rw_both", {31'b0, s_read_v[g] & s_write_v[g]}, 32'd0);
      chk("grant_onehot", {31'b0, $onehot0(grant_v[g])}, 32'd1);
    end
    if (reset && (m0_read | m0_write) && !m0_waitrequest) sb_pop(1'b0);
    if (reset && (m1_read | m1_write) && !m1_waitrequest) sb_pop(1'b1);
  end

  task automatic drive(input bit p, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (p) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end
  endtask

  // one Avalon transfer: hold request until accepted, drop it after the edge
  task automatic issue(input bit p, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    bit   done;
    done = 0;
    e.wr = wr; e.addr = a; e.data = d;
    if (p) q1.push_back(e); else q0.push_back(e);
    drive(p, !wr, wr, a, wr ? d : 32'h0, be);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = p ? ((m1_read | m1_write) && !m1_waitrequest)
               : ((m0_read | m0_write) && !m0_waitrequest);
    end
    if (!done) chk("xfer_timeout", {31'b0, p}, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, a, 32'h0, be);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0] = 32'h2402_0005;                     // word at 0xBFC00000
    sel = 1'b0;
    ram_wait = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_s_rw", {30'b0, s_read, s_write}, 32'd0);
    chk("rst_s_addr", s_address, 32'd0);
    chk("rst_s_be", {28'b0, s_byteenable}, 32'd0);
    chk("rst_wait", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);
    @(posedge clk); #1 reset = 1'b1;

    // single fetch read with two RAM wait states
    ram_wait = 2;
    fork
      issue(1'b1, 1'b0, 32'hBFC0_0000, 32'h2402_0005, 4'hF);
      begin
        @(negedge clk);
        chk("rd_grant_lat0", {30'b0, grant}, 32'd0);
        @(negedge clk);
        chk("rd_grant", {30'b0, grant}, 32'h2);
        chk("rd_s_read", {31'b0, s_read}, 32'd1);
        chk("rd_s_addr", s_address, 32'hBFC0_0000);
        chk("rd_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
        chk("rd_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rd_idle", {30'b0, grant}, 32'd0);
      end
    join

    // contention from reset: port 0 first, port 1 on the next edge
    do_reset();
    ram_wait = 1;
    fork
      issue(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
      issue(1'b1, 1'b0, 32'hBFC0_0000, 32'h2402_0005, 4'hF);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("cont_first", {30'b0, grant}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("cont_second", {30'b0, grant}, 32'h2);
      end
    join
    chk("cont_ram", mem[12'h400], 32'hDEAD_BEEF);

    // starvation bound under fixed priority
    sel = 1'b1;
    do_reset();
    ram_wait = 0;
    m0_done = 0; m1_done = 0; starv_on = 1;
    fork
      for (int i = 0; i < 10; i++) issue(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA500_0000 + 32'(i), 4'hF);
      for (int i = 0; i < 3; i++)  issue(1'b1, 1'b0, 32'hBFC0_0000, 32'h2402_0005, 4'hF);
    join
    starv_on = 0;
    chk("starve_m0_total", m0_done, 32'd10);
    chk("starve_m1_total", m1_done, 32'd3);
    chk("starve_ram", mem[12'h049], 32'hA500_0009);

    // reset asserted while port 0 write is stalled
    sel = 1'b0;
    do_reset();
    ram_wait = 3;
    drive(1'b0, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant", {30'b0, grant}, 32'h1);
    chk("mid_s_write", {31'b0, s_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_s_write", {31'b0, s_write}, 32'd0);
    chk("mid_rst_wait", {30'b0, m0_waitrequest, m1_waitrequest}, 32'd3);
    chk("mid_rst_grant", {30'b0, grant}, 32'd0);
    chk("mid_rst_addr", s_address, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    chk("mid_ram_kept", mem[12'h800], 32'h0);
    fork
      issue(1'b0, 1'b1, 32'h2000, 32'h1234_5678, 4'hF);
      begin
        @(negedge clk);
        chk("post_rst_lat0", {30'b0, grant}, 32'd0);
        @(negedge clk);
        chk("post_rst_grant", {30'b0, grant}, 32'h1);
      end
    join
    chk("post_rst_ram", mem[12'h800], 32'h1234_5678);

    // read and write together: write wins
    settle();
    ram_wait = 0;
    q0.push_back('{wr: 1'b1, addr: 32'h3000, data: 32'hCAFE_F00D});
    drive(1'b0, 1'b1, 1'b1, 32'h3000, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("rw_s_write", {31'b0, s_write}, 32'd1);
    chk("rw_s_read", {31'b0, s_read}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    chk("rw_ram", mem[12'hC00], 32'hCAFE_F00D);

    // port 1 drops its read mid-wait: abort to IDLE
    ram_wait = 3;
    drive(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("drop_grant", {30'b0, grant}, 32'h2);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h4000, 32'h0, 4'hF);
    @(negedge clk);
    chk("drop_s_read", {31'b0, s_read}, 32'd0);
    @(negedge clk);
    chk("drop_idle", {30'b0, grant}, 32'd0);

    // round-robin tie after a port 0 completion goes to port 1
    settle();
    ram_wait = 0;
    fork
      issue(1'b0, 1'b1, 32'h3004, 32'h1111_2222, 4'hF);
      issue(1'b1, 1'b0, 32'h3000, 32'hCAFE_F00D, 4'hF);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("rr_tie", {30'b0, grant}, 32'h2);
      end
    join
    settle();
    chk("rr_ram", mem[12'hC01], 32'h1111_2222);

    chk("sb_leftover", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
